// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and a small decode helper.
//   DEF_* : default 640x480@60 timing (pixels / lines) and clk-per-pixel
//   H_TOTAL, V_TOTAL, HS_*/VS_* : derived totals and sync windows
//   (each window is half-open: START <= count < END)
//   in_window() : unsigned half-open range test on a 10-bit counter
package vga_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_CLK_DIV   = 2;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up-counter with synchronous active-high reset.
//   Clk   : clock
//   Reset : synchronous reset, clears count
//   en    : advance by one on this edge
//   count : current value, 0..MODULUS-1
//   wrap  : combinational, high when the enabled edge takes count back to 0
module mod_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = H_TOTAL
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign wrap  = en && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator on a single clock.
//   Clk, Reset   : clock, synchronous active-high reset
//   pix_en       : one-Clk pulse per pixel advance (every CLK_DIV clocks)
//   DrawX, DrawY : current pixel / line counters
//   VGA_HS/VS    : active-low syncs, registered
//   VGA_BLANK_N  : high inside the visible area, registered
//   VGA_SYNC_N   : constant 0 (no sync-on-green)
//   frame_start  : one-Clk pulse on the first cycle of each new frame
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic             frame_start
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_VISIBLE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_params
      $error("vga_timing_gen: illegal parameters (CLK_DIV < 1 or total > 1024)");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] x_q, y_q, x_d, y_d;
  logic             h_wrap, v_wrap;

  mod_counter #(.MODULUS(H_TOT)) u_h_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (pix_en_q),
    .count (x_q),
    .wrap  (h_wrap)
  );

  // v_wrap implies h_wrap, so both counters return to 0 on the same edge.
  mod_counter #(.MODULUS(V_TOT)) u_v_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (h_wrap),
    .count (y_q),
    .wrap  (v_wrap)
  );

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_d = (div_q == DIV_LAST);

    // Mirror the counters' next values so the sync/blank flops can be
    // decoded one cycle early and update on the same edge as DrawX/DrawY.
    x_d = x_q;
    if (h_wrap)        x_d = '0;
    else if (pix_en_q) x_d = x_q + CNT_W'(1);

    y_d = y_q;
    if (v_wrap)      y_d = '0;
    else if (h_wrap) y_d = y_q + CNT_W'(1);

    hs_d          = !in_window(x_d, HS_LO, HS_HI);
    vs_d          = !in_window(y_d, VS_LO, VS_HI);
    blank_n_d     = in_window(x_d, 0, H_VISIBLE) && in_window(y_d, 0, V_VISIBLE);
    frame_start_d = v_wrap;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance (line-level checks)
// and a shrunken instance (15x10 raster, CLK_DIV=3) for whole-frame checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       pe_a, hs_a, vs_a, bn_a, sn_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, hs_b, vs_b, bn_b, sn_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_timing_gen dut_a (
    .Clk(clk), .Reset(rst_a), .pix_en(pe_a), .DrawX(x_a), .DrawY(y_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
    .frame_start(fs_a)
  );

  // H: 8/2/3/2 -> total 15, HS low x in 10..12
  // V: 6/1/2/1 -> total 10, VS low y in 7..8 ; frame = 150 pix = 450 clk
  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .pix_en(pe_b), .DrawX(x_b), .DrawY(y_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
    .frame_start(fs_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int fs_cnt_a = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fs_a === 1'b1) fs_cnt_a++;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_a_x(input int target, input string tag);
    int found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      @(negedge clk);
      if (int'(x_a) == target) found = 1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    int pcnt, done;
    int t0, t1, found;
    int px, py, ppe, ex, ey;
    int ctr_err, dec_err, vs_pix, vis_pix, all_pix;
    int bn_8_0, bn_0_6, bn_7_5;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst pix_en", pe_a, 0);
    check("rst DrawX", x_a, 0);
    check("rst DrawY", y_a, 0);
    check("rst HS", hs_a, 1);
    check("rst VS", vs_a, 1);
    check("rst BLANK_N", bn_a, 1);
    check("rst SYNC_N", sn_a, 0);
    check("rst frame_start", fs_a, 0);
    check("rst_b frame_start", fs_b, 0);

    // ---------------- default instance ----------------
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("start DrawX[%0d]", i), x_a, i / 2);
      check($sformatf("start pix_en[%0d]", i), pe_a, i % 2);
    end

    wait_a_x(639, "reach x639");
    check("BLANK_N at (639,0)", bn_a, 1);
    wait_a_x(640, "reach x640");
    check("BLANK_N at (640,0)", bn_a, 0);
    wait_a_x(655, "reach x655");
    check("HS at 655", hs_a, 1);
    wait_a_x(656, "reach x656");
    check("HS at 656", hs_a, 0);

    pcnt = 0;
    done = 0;
    for (int i = 0; i < 400 && done == 0; i++) begin
      if (hs_a == 1'b0) begin
        if (pe_a) pcnt++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    check("HS pulse ended", done, 1);
    check("DrawX at HS rise", x_a, 752);
    check("HS low pix_en count", pcnt, 96);

    wait_a_x(799, "reach x799");
    check("DrawY before wrap", y_a, 0);
    wait_a_x(0, "reach x0 line1");
    check("DrawY after wrap", y_a, 1);
    check("BLANK_N at (0,1)", bn_a, 1);
    check("no frame_start dut_a", fs_cnt_a, 0);

    // ---------------- small instance: full frame ----------------
    rst_b = 1'b0;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (fs_b) found = 1;
    end
    check("first frame_start", found, 1);
    check("fs DrawX", x_b, 0);
    check("fs DrawY", y_b, 0);
    t0 = cyc;

    ctr_err = 0; dec_err = 0; vs_pix = 0; vis_pix = 0; all_pix = 0;
    bn_8_0 = 2; bn_0_6 = 2; bn_7_5 = 2;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      if (i > 0) begin
        ex = ppe ? ((px == 14) ? 0 : px + 1) : px;
        ey = (ppe && px == 14) ? ((py == 9) ? 0 : py + 1) : py;
        if (int'(x_b) != ex || int'(y_b) != ey) ctr_err++;
      end
      if (hs_b !== !(x_b >= 10 && x_b < 13)) dec_err++;
      if (vs_b !== !(y_b >= 7 && y_b < 9))   dec_err++;
      if (bn_b !== (x_b < 8 && y_b < 6))     dec_err++;
      if (pe_b) begin
        all_pix++;
        if (!vs_b) vs_pix++;
        if (bn_b)  vis_pix++;
      end
      if (x_b == 8 && y_b == 0) bn_8_0 = bn_b;
      if (x_b == 0 && y_b == 6) bn_0_6 = bn_b;
      if (x_b == 7 && y_b == 5) bn_7_5 = bn_b;
      px = int'(x_b); py = int'(y_b); ppe = pe_b;
      @(negedge clk);
      if (fs_b) found = 1;
    end
    t1 = cyc;
    check("second frame_start", found, 1);
    check("frame period clk", t1 - t0, 450);
    check("counter step errors", ctr_err, 0);
    check("sync/blank decode errors", dec_err, 0);
    check("pix_en per frame", all_pix, 150);
    check("VS low pix_en", vs_pix, 30);
    check("visible pix_en", vis_pix, 48);
    check("BLANK_N at (8,0)", bn_8_0, 0);
    check("BLANK_N at (0,6)", bn_0_6, 0);
    check("BLANK_N at (7,5)", bn_7_5, 1);

    // ---------------- small instance: mid-frame reset ----------------
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (x_b == 5 && y_b == 3 && pe_b == 1'b0) found = 1;
    end
    check("reach (5,3) idle", found, 1);
    rst_b = 1'b1;
    @(negedge clk);
    check("midrst DrawX", x_b, 0);
    check("midrst DrawY", y_b, 0);
    check("midrst pix_en", pe_b, 0);
    check("midrst HS", hs_b, 1);
    check("midrst VS", vs_b, 1);
    check("midrst frame_start", fs_b, 0);
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("restart DrawX[%0d]", i), x_b, i / 3);
      check($sformatf("restart pix_en[%0d]", i), pe_b, (i % 3 == 2) ? 1 : 0);
      check($sformatf("restart fs[%0d]", i), fs_b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
